// File: rtl/audio_frame_fifo.sv
// Single-clock frame FIFO between the I2S receiver and the SPDIF transmitter.
// Each entry is one CHANNELS-wide frame (channel 0 in the low WORDSIZE bits).
// Status outputs are registered from the next-state level. data_out is
// either a first-word-fall-through view of the head or a 1-cycle registered read.
module audio_frame_fifo #(
  parameter int WORDSIZE   = 32,
  parameter int CHANNELS   = 2,
  parameter int DEPTH      = 8,
  parameter int FWFT       = 1,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            write_en,
  input  logic [CHANNELS*WORDSIZE-1:0]    data_in,
  input  logic                            read_en,
  output logic [CHANNELS*WORDSIZE-1:0]    data_out,
  output logic                            full,
  output logic                            empty,
  output logic                            almost_full,
  output logic                            almost_empty,
  output logic [$clog2(DEPTH):0]          level,
  output logic                            overflow,
  output logic                            underflow,
  input  logic                            clear_flags
);

  localparam int FW = CHANNELS * WORDSIZE;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(AFULL_LVL);
  localparam logic [LW-1:0] LVL_AE   = LW'(AEMPTY_LVL);

  logic [FW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [LW-1:0] level_nxt;
  logic [FW-1:0] dout_nxt;
  logic          wr_ok, rd_ok, wr_acc, ovf_set, udf_set;

  // Accept decisions, next pointers/level and the next data_out value.
  always_comb begin
    wr_ok      = write_en & (~full | read_en);
    rd_ok      = read_en & ~empty;
    wr_acc     = wr_ok & ~flush;
    ovf_set    = write_en & ~wr_ok & ~flush;
    udf_set    = read_en & ~rd_ok & ~flush;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    level_nxt  = level;
    dout_nxt   = data_out;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      level_nxt  = '0;
      dout_nxt   = '0;
    end else begin
      if (wr_ok) wr_ptr_nxt = wr_ptr + 1'b1;
      if (rd_ok) rd_ptr_nxt = rd_ptr + 1'b1;
      level_nxt = level + LW'(wr_ok) - LW'(rd_ok);
      if (FWFT != 0) begin
        // A frame written this edge that becomes the sole entry is not in
        // mem yet, so it is forwarded straight from data_in.
        if (level_nxt != '0) begin
          if (wr_ok && (level_nxt == LW'(1))) dout_nxt = data_in;
          else                                dout_nxt = mem[rd_ptr_nxt];
        end
      end else begin
        if (rd_ok) dout_nxt = mem[rd_ptr];
      end
    end
  end

  // Frame storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  // Pointers, level, registered status, output frame and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      data_out     <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      level        <= level_nxt;
      data_out     <= dout_nxt;
      full         <= (level_nxt == LVL_FULL);
      empty        <= (level_nxt == '0);
      almost_full  <= (level_nxt >= LVL_AF);
      almost_empty <= (level_nxt <= LVL_AE);
      overflow     <= ovf_set | (overflow & ~clear_flags);
      underflow    <= udf_set | (underflow & ~clear_flags);
    end
  end

endmodule

// File: tb/tb_audio_frame_fifo.sv
// Scoreboard bench: two instances (2-channel FWFT, 4-channel registered read).
module tb_audio_frame_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance 0: 2 channels, FWFT
  logic        rst0, flush0, we0, re0, cf0;
  logic [63:0] din0, dout0;
  logic        full0, empty0, af0, ae0, ovf0, udf0;
  logic [3:0]  level0;
  logic [63:0] q0[$];

  // Instance 1: 4 channels, registered read
  logic         rst1, flush1, we1, re1, cf1;
  logic [127:0] din1, dout1;
  logic         full1, empty1, af1, ae1, ovf1, udf1;
  logic [3:0]   level1;
  logic [127:0] q1[$];

  audio_frame_fifo #(.WORDSIZE(32), .CHANNELS(2), .DEPTH(8), .FWFT(1),
                     .AFULL_LVL(6), .AEMPTY_LVL(2)) dut0 (
    .clk(clk), .rst(rst0), .flush(flush0), .write_en(we0), .data_in(din0),
    .read_en(re0), .data_out(dout0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .level(level0),
    .overflow(ovf0), .underflow(udf0), .clear_flags(cf0));

  audio_frame_fifo #(.WORDSIZE(32), .CHANNELS(4), .DEPTH(8), .FWFT(0),
                     .AFULL_LVL(6), .AEMPTY_LVL(2)) dut1 (
    .clk(clk), .rst(rst1), .flush(flush1), .write_en(we1), .data_in(din1),
    .read_en(re1), .data_out(dout1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .level(level1),
    .overflow(ovf1), .underflow(udf1), .clear_flags(cf1));

  task automatic cyc0(input logic we, input logic re, input logic fl,
                      input logic cf, input logic [63:0] d);
    we0 = we; re0 = re; flush0 = fl; cf0 = cf; din0 = d;
    @(posedge clk); #1;
    we0 = 0; re0 = 0; flush0 = 0; cf0 = 0;
  endtask

  task automatic cyc1(input logic we, input logic re, input logic [127:0] d);
    we1 = we; re1 = re; din1 = d;
    @(posedge clk); #1;
    we1 = 0; re1 = 0;
  endtask

  task automatic test_reset;
    rst0 = 1; rst1 = 1; flush0 = 0; we0 = 0; re0 = 0; cf0 = 0; din0 = '0;
    flush1 = 0; we1 = 0; re1 = 0; cf1 = 0; din1 = '0;
    #2; rst0 = 0; rst1 = 0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (level0 !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level0); end
    checks++; if (empty0 !== 1'b1 || ae0 !== 1'b1) begin errors++; $display("FAIL reset_empty got %b%b exp 11", empty0, ae0); end
    checks++; if (full0 !== 1'b0 || af0 !== 1'b0) begin errors++; $display("FAIL reset_full got %b%b exp 00", full0, af0); end
    checks++; if (ovf0 !== 1'b0 || udf0 !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", ovf0, udf0); end
    checks++; if (dout0 !== 64'd0) begin errors++; $display("FAIL reset_dout got %h exp 0", dout0); end
    rst0 = 1; rst1 = 1;
  endtask

  task automatic test_fill_drain;
    logic [63:0] f, exp;
    for (int i = 1; i <= 8; i++) begin
      f = {32'h80000000 | 32'(i), 32'(i)};
      q0.push_back(f);
      cyc0(1, 0, 0, 0, f);
      checks++; if (level0 !== 4'(i)) begin errors++; $display("FAIL fill_level got %0d exp %0d", level0, i); end
      checks++; if (af0 !== (i >= 6)) begin errors++; $display("FAIL fill_afull i=%0d got %b", i, af0); end
      checks++; if (ae0 !== (i <= 2)) begin errors++; $display("FAIL fill_aempty i=%0d got %b", i, ae0); end
    end
    checks++; if (full0 !== 1'b1) begin errors++; $display("FAIL full_after8 got %b exp 1", full0); end
    cyc0(1, 0, 0, 0, 64'hDEAD_BEEF_DEAD_BEEF);
    checks++; if (ovf0 !== 1'b1 || level0 !== 4'd8) begin errors++; $display("FAIL overflow got ovf=%b lvl=%0d exp 1/8", ovf0, level0); end
    for (int i = 0; i < 8; i++) begin
      exp = q0.pop_front();
      checks++; if (dout0 !== exp) begin errors++; $display("FAIL drain_data got %h exp %h", dout0, exp); end
      cyc0(0, 1, 0, 0, '0);
      checks++; if (level0 !== 4'(7 - i) || ae0 !== ((7 - i) <= 2)) begin errors++; $display("FAIL drain_level got %0d ae=%b exp %0d", level0, ae0, 7 - i); end
    end
    checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL empty_after_drain got %b exp 1", empty0); end
    checks++; if (dout0 !== {32'h80000008, 32'h8}) begin errors++; $display("FAIL dout_hold got %h", dout0); end
    cyc0(0, 1, 0, 0, '0);
    checks++; if (udf0 !== 1'b1 || level0 !== 4'd0) begin errors++; $display("FAIL underflow got udf=%b lvl=%0d exp 1/0", udf0, level0); end
  endtask

  task automatic test_simultaneous;
    logic [63:0] f, exp, nf;
    cyc0(0, 0, 0, 1, '0);
    checks++; if (ovf0 !== 1'b0 || udf0 !== 1'b0) begin errors++; $display("FAIL clear_flags got %b%b exp 00", ovf0, udf0); end
    for (int i = 1; i <= 8; i++) begin
      f = {32'h90000000 | 32'(i), 32'h10000000 | 32'(i)};
      q0.push_back(f);
      cyc0(1, 0, 0, 0, f);
    end
    exp = q0.pop_front();
    checks++; if (dout0 !== exp) begin errors++; $display("FAIL full_rw_head got %h exp %h", dout0, exp); end
    nf = 64'hCAFE0001_BABE0001;
    q0.push_back(nf);
    cyc0(1, 1, 0, 0, nf);
    checks++; if (level0 !== 4'd8 || full0 !== 1'b1 || ovf0 !== 1'b0) begin errors++; $display("FAIL full_rw_status got lvl=%0d full=%b ovf=%b exp 8/1/0", level0, full0, ovf0); end
    for (int i = 0; i < 8; i++) begin
      exp = q0.pop_front();
      checks++; if (dout0 !== exp) begin errors++; $display("FAIL full_rw_order got %h exp %h", dout0, exp); end
      cyc0(0, 1, 0, 0, '0);
    end
    nf = 64'h12345678_9ABCDEF0;
    cyc0(1, 1, 0, 0, nf);
    checks++; if (level0 !== 4'd1 || udf0 !== 1'b1 || empty0 !== 1'b0) begin errors++; $display("FAIL empty_rw got lvl=%0d udf=%b empty=%b exp 1/1/0", level0, udf0, empty0); end
    checks++; if (dout0 !== nf) begin errors++; $display("FAIL empty_rw_fwft got %h exp %h", dout0, nf); end
    cyc0(0, 1, 0, 0, '0);
    checks++; if (level0 !== 4'd0 || empty0 !== 1'b1) begin errors++; $display("FAIL empty_rw_pop got lvl=%0d empty=%b", level0, empty0); end
  endtask

  task automatic test_flush;
    logic [63:0] f, exp;
    for (int i = 1; i <= 9; i++) begin
      f = {32'hA0000000 | 32'(i), 32'h20000000 | 32'(i)};
      if (i <= 8) q0.push_back(f);
      cyc0(1, 0, 0, 0, f);
    end
    for (int i = 0; i < 3; i++) begin
      exp = q0.pop_front();
      checks++; if (dout0 !== exp) begin errors++; $display("FAIL pre_flush_data got %h exp %h", dout0, exp); end
      cyc0(0, 1, 0, 0, '0);
    end
    checks++; if (level0 !== 4'd5 || ovf0 !== 1'b1) begin errors++; $display("FAIL pre_flush got lvl=%0d ovf=%b exp 5/1", level0, ovf0); end
    cyc0(1, 0, 1, 0, 64'h5555_5555_5555_5555);
    q0.delete();
    checks++; if (level0 !== 4'd0 || empty0 !== 1'b1 || ae0 !== 1'b1) begin errors++; $display("FAIL flush_level got lvl=%0d empty=%b", level0, empty0); end
    checks++; if (dout0 !== 64'd0) begin errors++; $display("FAIL flush_dout got %h exp 0", dout0); end
    checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL flush_keeps_ovf got %b exp 1", ovf0); end
    cyc0(0, 0, 0, 1, '0);
    checks++; if (ovf0 !== 1'b0 || udf0 !== 1'b0) begin errors++; $display("FAIL clear_after_flush got %b%b exp 00", ovf0, udf0); end
    f = 64'h0F0F0F0F_F0F0F0F0;
    cyc0(1, 0, 0, 0, f);
    checks++; if (dout0 !== f || level0 !== 4'd1) begin errors++; $display("FAIL post_flush_push got %h lvl=%0d exp %h/1", dout0, level0, f); end
  endtask

  task automatic test_wrap_fwft0;
    logic [127:0] f, exp;
    for (int i = 0; i < 3; i++) begin
      f = {$urandom(), $urandom(), $urandom(), $urandom()};
      q1.push_back(f);
      cyc1(1, 0, f);
    end
    checks++; if (dout1 !== 128'd0 || level1 !== 4'd3) begin errors++; $display("FAIL reg_prefill got %h lvl=%0d exp 0/3", dout1, level1); end
    for (int i = 0; i < 20; i++) begin
      f = {$urandom(), $urandom(), $urandom(), $urandom()};
      exp = q1.pop_front();
      q1.push_back(f);
      cyc1(1, 1, f);
      checks++; if (dout1 !== exp || level1 !== 4'd3) begin errors++; $display("FAIL wrap_pair%0d got %h lvl=%0d exp %h", i, dout1, level1, exp); end
    end
    cyc1(0, 0, '0);
    checks++; if (dout1 !== exp) begin errors++; $display("FAIL reg_hold got %h exp %h", dout1, exp); end
    for (int i = 0; i < 3; i++) begin
      exp = q1.pop_front();
      cyc1(0, 1, '0);
      checks++; if (dout1 !== exp) begin errors++; $display("FAIL reg_drain got %h exp %h", dout1, exp); end
    end
    checks++; if (empty1 !== 1'b1 || udf1 !== 1'b0) begin errors++; $display("FAIL reg_empty got %b udf=%b", empty1, udf1); end
  endtask

  task automatic test_async_reset;
    logic [127:0] f, exp;
    for (int i = 0; i < 3; i++) begin
      f = {32'h11110000 | 32'(i), 32'h22220000 | 32'(i), 32'h33330000 | 32'(i), 32'h44440000 | 32'(i)};
      q1.push_back(f);
      cyc1(1, 0, f);
    end
    exp = q1.pop_front();
    cyc1(0, 1, '0);
    checks++; if (dout1 !== exp) begin errors++; $display("FAIL pre_reset_data got %h exp %h", dout1, exp); end
    #3; rst1 = 0; #1;
    q1.delete();
    checks++; if (level1 !== 4'd0 || empty1 !== 1'b1 || ae1 !== 1'b1 || full1 !== 1'b0) begin errors++; $display("FAIL async_reset_status got lvl=%0d empty=%b", level1, empty1); end
    checks++; if (dout1 !== 128'd0) begin errors++; $display("FAIL async_reset_dout got %h exp 0", dout1); end
    @(posedge clk); #1;
    rst1 = 1;
    f = {32'hD, 32'hC, 32'hB, 32'hA};
    cyc1(1, 0, f);
    cyc1(1, 0, 128'h1);
    cyc1(0, 1, '0);
    checks++; if (dout1 !== f || level1 !== 4'd1) begin errors++; $display("FAIL post_reset_first got %h lvl=%0d exp %h/1", dout1, level1, f); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_flush();
    test_wrap_fwft0();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_frame_fifo.md
Name: audio_frame_fifo

Overview:
Parametrised successor to the stereo sample FIFO. It buffers CHANNELS-wide audio frames between the I2S receive side and the SPDIF transmit side in one clock domain. Compared with the two-channel version it adds:
- a configurable channel count
- a selectable read mode: first-word-fall-through or registered
- almost-full and almost-empty thresholds
- a fill-level output
- sticky overflow and underflow flags
- a synchronous flush

Parameters:
- WORDSIZE, 32: bits per channel sample.
- CHANNELS, 2: channels per frame; range 1..8.
- DEPTH, 8: frame capacity; must be a power of two, at least 2.
- FWFT, 1: 1 = first-word-fall-through; 0 = registered read with 1-cycle latency.
- AFULL_LVL, DEPTH-2: almost_full asserts when level >= AFULL_LVL.
- AEMPTY_LVL, 2: almost_empty asserts when level <= AEMPTY_LVL.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- flush  in  1  synchronous clear of contents.
- write_en  in  1  push request.
- data_in  in  CHANNELS*WORDSIZE  frame to push; channel 0 in bits [WORDSIZE-1:0] (left), channel 1 in the next WORDSIZE bits (right), and so on.
- read_en  in  1  pop request.
- data_out  out  CHANNELS*WORDSIZE  frame output; same channel packing as data_in.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= AFULL_LVL.
- almost_empty  out  1  level <= AEMPTY_LVL.
- level  out  $clog2(DEPTH)+1  frames currently stored.
- overflow  out  1  sticky; a write was rejected.
- underflow  out  1  sticky; a read was rejected.
- clear_flags  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset state (rst low, asynchronous, takes effect immediately):
  - pointers = 0, level = 0, data_out = 0
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0
  - overflow = 0, underflow = 0
  - Deassertion is synchronous to clk; the first push is accepted on the first rising edge with rst high.
- Storage: DEPTH x (CHANNELS*WORDSIZE) array. Read and write pointers are $clog2(DEPTH) bits, increment by 1 and wrap from DEPTH-1 to 0. Level is tracked by a separate counter.
- Accept rules, evaluated each rising edge:
  - wr_ok = write_en & (!full | read_en)
  - rd_ok = read_en & !empty
  - When full and both requests are asserted, both are accepted; level is unchanged and the pointers advance.
  - When empty and both are asserted, only the write is accepted; underflow is set.
- Level update: level_next = level + wr_ok - rd_ok. All status flags (full, empty, almost_full, almost_empty) are registered outputs that reflect level_next, i.e. they are valid in the cycle after the event.
- FWFT=1:
  - data_out always shows the head frame while !empty.
  - A pop on edge N advances data_out to the next frame after edge N.
  - A write into an empty FIFO appears on data_out 1 cycle later, in the same cycle that empty deasserts.
  - data_out holds its last value when the FIFO becomes empty.
- FWFT=0:
  - data_out is registered; it updates on the edge at which rd_ok = 1, giving 1-cycle read latency.
  - data_out holds otherwise.
- overflow: set on any edge with write_en & !wr_ok.
- underflow: set on any edge with read_en & !rd_ok.
- clear_flags clears both sticky flags. If a new error occurs on the same edge, the set wins.
- flush (synchronous, highest priority after reset):
  - zeroes the pointers and level; data_out = 0
  - write and read requests on the same edge are ignored and do not set the error flags
  - sticky flags are unaffected
- Reset mid-operation: all contents are discarded and outputs return to reset values without waiting for clk.
- Data integrity: frames exit in push order. Channel lanes never mix across frames.

Test Plan:
1. Reset and defaults, CHANNELS=2, DEPTH=8, FWFT=1:
   - Hold rst low 10 cycles, then push frames {L=0x00000001,R=0x80000001} .. {L=0x00000008,R=0x80000008}.
   - Required: full=1 and level=8 after the 8th push.
   - A 9th push sets overflow=1 and level stays 8.
   - 8 pops return frames 1..8 in order; empty=1 afterwards.
   - A 9th pop sets underflow=1.
2. Thresholds, DEPTH=8, AFULL_LVL=6, AEMPTY_LVL=2:
   - almost_full rises in the cycle after the 6th push.
   - almost_empty falls after the 3rd push and re-asserts when level returns to 2.
3. Simultaneous push and pop:
   - When full with read_en=write_en=1: level stays 8, the oldest frame is popped and the new frame is stored at the wrapped tail.
   - When empty with both asserted: level = 1 next cycle and underflow=1.
4. Wrap-around and FWFT=0 latency:
   - Perform 20 interleaved push/pop pairs with 3 frames resident, so the pointers wrap at least twice.
   - Required: data_out matches the push order, each frame appearing 1 cycle after the rd_ok edge; no frame is lost or duplicated.
5. Flush and flags:
   - With level=5, overflow=1, assert flush together with write_en.
   - Required: level=0, empty=1, data_out=0, overflow still 1.
   - Then assert clear_flags: overflow=0.
6. Asynchronous reset mid-burst, CHANNELS=4:
   - Drop rst between clock edges after 3 pushes.
   - Required: outputs reach reset values before the next edge; the first frame pushed after release, 0xA/0xB/0xC/0xD, is the first frame popped.
